// File: rtl/irig_frame_sync_if.sv
// Symbol-in / time-out bundle between the IRIG-B decoder side and the frame synchronizer.
interface irig_frame_sync_if;
    logic       irig_mark;
    logic       irig_d1;
    logic       irig_d0;
    logic       locked;
    logic       ts_valid;
    logic [6:0] ts_sec;
    logic [6:0] ts_min;
    logic [5:0] ts_hour;
    logic [9:0] ts_day;
    logic [7:0] ts_year;
    logic       frame_err;
    logic       timeout;

    // Symbol source / time consumer side.
    modport master (
        output irig_mark, irig_d1, irig_d0,
        input  locked, ts_valid, ts_sec, ts_min, ts_hour, ts_day, ts_year, frame_err, timeout
    );

    // Frame synchronizer side.
    modport slave (
        input  irig_mark, irig_d1, irig_d0,
        output locked, ts_valid, ts_sec, ts_min, ts_hour, ts_day, ts_year, frame_err, timeout
    );
endinterface

// File: rtl/irig_frame_sync.sv
// IRIG-B frame synchronizer: locks on the P0/Pr double marker, tracks symbol position 0..99,
// checks every position marker and publishes the BCD time fields once per frame.
module irig_frame_sync #(
    parameter int unsigned TIMEOUT_CYCLES = 15000
) (
    input  logic              clk,
    input  logic              rst_n,
    irig_frame_sync_if.slave  bus
);

    typedef enum logic [1:0] {StHunt, StMark1, StLocked} state_e;

    state_e      state_q, state_d;
    logic [6:0]  pos_q, pos_d;
    logic [16:0] wdog_q, wdog_d;
    logic [98:1] raw_q, raw_d;
    logic        locked_q, locked_d;
    logic        ts_valid_q, ts_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        timeout_q, timeout_d;
    logic [6:0]  sec_q, sec_d;
    logic [6:0]  min_q, min_d;
    logic [5:0]  hour_q, hour_d;
    logic [9:0]  day_q, day_d;
    logic [7:0]  year_q, year_d;

    logic        sym_mark, sym_d1, sym_d0;
    logic        sym_any, sym_illegal;
    logic [6:0]  pos_adv;
    logic        mark_expected;
    logic        wdog_expired;

    assign sym_mark    = bus.irig_mark;
    assign sym_d1      = bus.irig_d1;
    assign sym_d0      = bus.irig_d0;
    assign sym_any     = sym_mark | sym_d1 | sym_d0;
    assign sym_illegal = (sym_mark & sym_d1) | (sym_mark & sym_d0) | (sym_d1 & sym_d0);

    // Position the incoming symbol occupies once pos has advanced.
    assign pos_adv       = (pos_q == 7'd99) ? 7'd0 : pos_q + 7'd1;
    assign mark_expected = (pos_adv == 7'd0) || ((pos_adv % 7'd10) == 7'd9);
    assign wdog_expired  = (wdog_q == 17'(TIMEOUT_CYCLES));

    // Index positions and reserved/control bits are captured but never published.
    logic unused_raw;
    assign unused_raw = ^{raw_q[98:59], raw_q[54], raw_q[49:42], raw_q[39], raw_q[34],
                          raw_q[29:27], raw_q[24], raw_q[19:18], raw_q[14], raw_q[9], raw_q[5]};

    // Next-state: sync FSM, position tracking, capture, publish and watchdog.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        wdog_d      = wdog_q;
        raw_d       = raw_q;
        ts_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_d       = day_q;
        year_d      = year_q;

        unique case (state_q)
            StHunt: begin
                wdog_d = '0;
                if (sym_illegal) begin
                    state_d = StHunt;
                end else if (sym_mark) begin
                    state_d = StMark1;
                end
            end
            StMark1: begin
                if (!sym_any) begin
                    if (wdog_expired) begin
                        timeout_d = 1'b1;
                        state_d   = StHunt;
                        wdog_d    = '0;
                    end else begin
                        wdog_d = wdog_q + 17'd1;
                    end
                end else begin
                    wdog_d = '0;
                    if (sym_illegal || !sym_mark) begin
                        state_d = StHunt;
                    end else begin
                        // Second marker of the pair is Pr, position 0.
                        state_d = StLocked;
                        pos_d   = 7'd0;
                    end
                end
            end
            StLocked: begin
                if (!sym_any) begin
                    if (wdog_expired) begin
                        timeout_d = 1'b1;
                        state_d   = StHunt;
                        wdog_d    = '0;
                    end else begin
                        wdog_d = wdog_q + 17'd1;
                    end
                end else begin
                    wdog_d = '0;
                    pos_d  = pos_adv;
                    if (sym_illegal) begin
                        frame_err_d = 1'b1;
                        state_d     = StHunt;
                    end else if (sym_mark) begin
                        if (!mark_expected) begin
                            // A stray mark may itself be the P0 of a new frame.
                            frame_err_d = 1'b1;
                            state_d     = StMark1;
                        end else if (pos_adv == 7'd99) begin
                            ts_valid_d = 1'b1;
                            sec_d      = {raw_q[8:6], raw_q[4:1]};
                            min_d      = {raw_q[17:15], raw_q[13:10]};
                            hour_d     = {raw_q[26:25], raw_q[23:20]};
                            day_d      = {raw_q[41:40], raw_q[38:35], raw_q[33:30]};
                            year_d     = {raw_q[58:55], raw_q[53:50]};
                        end
                    end else begin
                        if (mark_expected) begin
                            frame_err_d = 1'b1;
                            state_d     = StHunt;
                        end else begin
                            // Positions 0 and 99 are markers, so pos_adv is within 1..98 here.
                            raw_d[pos_adv] = sym_d1;
                        end
                    end
                end
            end
            default: begin
                state_d = StHunt;
                wdog_d  = '0;
            end
        endcase

        locked_d = (state_d == StLocked);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            pos_q       <= '0;
            wdog_q      <= '0;
            raw_q       <= '0;
            locked_q    <= 1'b0;
            ts_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= '0;
            year_q      <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            wdog_q      <= wdog_d;
            raw_q       <= raw_d;
            locked_q    <= locked_d;
            ts_valid_q  <= ts_valid_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            year_q      <= year_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.ts_valid  = ts_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;
    assign bus.ts_sec    = sec_q;
    assign bus.ts_min    = min_q;
    assign bus.ts_hour   = hour_q;
    assign bus.ts_day    = day_q;
    assign bus.ts_year   = year_q;

endmodule
